lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: maximum WAIT cycles before a load is aborted; legal range 2..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port load_en, input, 1: pipeline requests a load this cycle.
REQ-005 SHALL have port store_en, input, 1: pipeline requests a store this cycle.
REQ-006 SHALL have port funct3, input, 3: access type, RV32I encoding.
REQ-007 SHALL have port alu_addr, input, 32: byte address; bits [31:10] ignored.
REQ-008 SHALL have port rs2_data, input, 32: store source data.
REQ-009 SHALL have port mem_valid, input, 1: load data ready from data memory.
REQ-010 SHALL have port mem_rdata, input, 32: word read from data memory.
REQ-011 SHALL have port mem_we_re, output, 1: 1 = write, 0 = read.
REQ-012 SHALL have port mem_request, output, 1: memory access strobe.
REQ-013 SHALL have port mem_load, output, 1: load marker; data memory returns valid one cycle later.
REQ-014 SHALL have port mem_mask, output, 4: byte-lane enables; bit n covers byte n.
REQ-015 SHALL have port mem_addr, output, 8: word address, alu_addr[9:2].
REQ-016 SHALL have port mem_wdata, output, 32: lane-aligned store data.
REQ-017 SHALL have port stall, output, 1: freeze upstream pipeline.
REQ-018 SHALL have port wb_valid, output, 1: load result valid, registered one-cycle pulse.
REQ-019 SHALL have port wb_data, output, 32: extended load result, registered.
REQ-020 SHALL have port err, output, 1: error pulse, registered, one cycle.
REQ-021 SHALL have port err_code, output, 2: 01 misaligned, 10 illegal funct3, 11 timeout; held until the next err.

Function
REQ-022 SHALL implement FSM with states IDLE and WAIT; requests are accepted only in IDLE.
REQ-023 SHALL drive memory-side outputs combinationally from inputs in IDLE, and drive all of them 0 in WAIT and when no request is accepted.
REQ-024 SHALL give load_en priority when load_en and store_en are both high; the store is dropped with no error.
REQ-025 SHALL accept a load in IDLE only if funct3 is in {000,001,010,100,101} and the access is aligned (half: addr[0]=0; word: addr[1:0]=00); on accept: mem_request=1, mem_load=1, mem_we_re=0, mem_mask=1111, stall=1, latch funct3 and addr[1:0], next state WAIT, counter cleared.
REQ-026 SHALL accept a store in IDLE only if funct3 is in {000,001,010} and the access is aligned; on accept: mem_request=1, mem_we_re=1, mem_load=0, stall=0; the FSM stays in IDLE.
REQ-027 SHALL generate store data and mask as follows: SB drives wdata={4{rs2[7:0]}} with mask=0001<<addr[1:0]; SH drives wdata={2{rs2[15:0]}} with mask=0011 or 1100 by addr[1]; SW drives wdata=rs2 with mask=1111.
REQ-028 SHALL hold stall=1 in every WAIT cycle.
REQ-029 SHALL, in WAIT with mem_valid=1, select the latched byte or half from mem_rdata, sign-extend it (LB/LH) or zero-extend it (LBU/LHU), or pass the word (LW); register the result to wb_data, pulse wb_valid next cycle, and return to IDLE; a back-to-back request is accepted in that next cycle.
REQ-030 SHALL increment the WAIT counter each WAIT cycle without mem_valid; on reaching TIMEOUT it SHALL pulse err with code 11, return to IDLE, and leave wb_valid low.
REQ-031 SHALL ignore mem_valid while in IDLE.
REQ-032 SHALL, for a rejected request (misaligned or illegal funct3), issue no memory access, keep stall=0, and pulse err next cycle with code 01, or 10 if funct3 is illegal (illegal takes precedence).
REQ-033 SHALL keep wb_data unchanged except on a load capture.

Reset
REQ-034 SHALL, with rst=0, asynchronously force state IDLE, counter 0, wb_valid 0, wb_data 0, err 0, err_code 00, and all latched fields 0.
REQ-035 SHALL abort a load that is in progress when reset is asserted, with no wb_valid after release; a mem_valid arriving after reset is ignored.

Verification
REQ-036 SHALL cover: LW at addr 0x10 with memory word 0xDEADBEEF -> cycle0 request/load with mem_addr=0x04 and stall=1; cycle1 stall=1; cycle2 wb_valid=1, wb_data=0xDEADBEEF, stall=0.
REQ-037 SHALL cover: LB addr 0x13 then LBU addr 0x13 with word 0x80FF1234 -> wb_data=0xFFFFFF80, then 0x00000080.
REQ-038 SHALL cover: SH addr 0x06 with rs2=0x0000ABCD -> mem_we_re=1, mem_mask=1100, mem_wdata=0xABCDABCD, mem_addr=0x01, stall=0.
REQ-039 SHALL cover: LW at addr 0x02 -> no mem_request; err pulse with err_code=01; stall=0.
REQ-040 SHALL cover: load with mem_valid held low for 8 WAIT cycles -> err with err_code=11, FSM back in IDLE, no wb_valid.
REQ-041 SHALL cover: load_en and store_en together -> read only (mem_we_re=0); rst pulsed low in WAIT -> outputs at reset values and no wb_valid.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: turns pipeline load/store requests into
// byte-lane data-memory accesses and returns sign/zero-extended load results.
// Latency: stores issue combinationally in the request cycle; loads return
// wb_valid two cycles after the request when memory answers one cycle later.
// Backpressure: stall is raised in the load request cycle and every WAIT cycle;
// a load with no mem_valid for TIMEOUT WAIT cycles is aborted with err code 11.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   load_en, store_en - pipeline request strobes (load wins if both set)
//   funct3, alu_addr  - RV32I access type and byte address (bits [31:10] unused)
//   rs2_data          - store source data
//   mem_valid/rdata   - load data return from data memory
//   mem_*             - memory-side strobe, direction, lanes, word address, data
//   stall             - freeze upstream pipeline
//   wb_valid/wb_data  - registered load result pulse
//   err/err_code      - registered error pulse; code held until the next error
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_addr,
    input  logic [31:0] rs2_data,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        mem_we_re,
    output logic        mem_request,
    output logic        mem_load,
    output logic [3:0]  mem_mask,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    // Upper address bits do not reach the 1 KiB data memory.
    logic        unused_addr;
    assign unused_addr = ^alu_addr[31:10];

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic idle;
    logic any_req;
    logic load_f3_ok;
    logic store_f3_ok;
    logic illegal;
    logic misaligned;
    logic accept_load;
    logic accept_store;
    logic reject;

    assign idle        = (state == ST_IDLE);
    assign any_req     = load_en | store_en;
    assign load_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                         (funct3 == 3'b100) || (funct3 == 3'b101);
    assign store_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    // A simultaneous store is silently dropped, so legality follows the load.
    assign illegal     = load_en ? !load_f3_ok : !store_f3_ok;
    // funct3[1:0] gives access size for every legal encoding.
    assign misaligned  = ((funct3[1:0] == 2'b01) && alu_addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (alu_addr[1:0] != 2'b00));

    assign accept_load  = idle && load_en && !illegal && !misaligned;
    assign accept_store = idle && !load_en && store_en && !illegal && !misaligned;
    assign reject       = idle && any_req && (illegal || misaligned);

    // ------------------------------------------------------------------
    // Memory-side outputs: combinational from the request in IDLE, else 0
    // ------------------------------------------------------------------
    always_comb begin
        mem_we_re   = 1'b0;
        mem_request = 1'b0;
        mem_load    = 1'b0;
        mem_mask    = 4'b0000;
        mem_addr    = 8'h00;
        mem_wdata   = 32'h0000_0000;
        stall       = (state == ST_WAIT);

        if (accept_load) begin
            mem_request = 1'b1;
            mem_load    = 1'b1;
            mem_mask    = 4'b1111;
            mem_addr    = alu_addr[9:2];
            stall       = 1'b1;
        end else if (accept_store) begin
            mem_request = 1'b1;
            mem_we_re   = 1'b1;
            mem_addr    = alu_addr[9:2];
            case (funct3[1:0])
                2'b00: begin
                    mem_wdata = {4{rs2_data[7:0]}};
                    mem_mask  = 4'b0001 << alu_addr[1:0];
                end
                2'b01: begin
                    mem_wdata = {2{rs2_data[15:0]}};
                    mem_mask  = alu_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    mem_wdata = rs2_data;
                    mem_mask  = 4'b1111;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load result extraction from the returned word
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

    always_comb begin
        ld_result = mem_rdata;
        case (lat_off)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_funct3)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_result = {24'h000000, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_result = {16'h0000, ld_half};
            default: ld_result = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered result and error outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            wb_valid   <= 1'b0;
            wb_data    <= 32'h0000_0000;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_load) begin
                        state      <= ST_WAIT;
                        wait_cnt   <= 4'd0;
                        lat_funct3 <= funct3;
                        lat_off    <= alu_addr[1:0];
                    end else if (reject) begin
                        err      <= 1'b1;
                        err_code <= illegal ? 2'b10 : 2'b01;
                    end
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= ld_result;
                        state    <= ST_IDLE;
                    end else if (wait_cnt == 4'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th WAIT cycle without data.
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        wait_cnt <= 4'd0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: table of single-cycle store/reject
// vectors plus hand-written load, timeout, priority and reset sequences.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic        store_en = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_addr = '0;
    logic [31:0] rs2_data = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_we_re;
    logic        mem_request;
    logic        mem_load;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_wb   = '0;
    logic [1:0]  exp_code = 2'b00;

    lsu_mem_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .store_en(store_en),
        .funct3(funct3), .alu_addr(alu_addr), .rs2_data(rs2_data),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_we_re(mem_we_re),
        .mem_request(mem_request), .mem_load(mem_load), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic        we;
        logic        req;
        logic [3:0]  mask;
        logic [7:0]  maddr;
        logic [31:0] wdata;
        logic        e;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2);
        load_en  = ld;
        store_en = st;
        funct3   = f3;
        alu_addr = addr;
        rs2_data = rs2;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Entered and left at posedge+1; leaves the DUT in IDLE with wb_valid showing.
    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input int waits,
                           input logic [31:0] exp, input logic both);
        drive(1'b1, both, f3, addr, 32'hFFFF_FFFF);
        #4;
        check({name, "_req"},   mem_request, 1);
        check({name, "_load"},  mem_load, 1);
        check({name, "_we"},    mem_we_re, 0);
        check({name, "_mask"},  mem_mask, 4'b1111);
        check({name, "_maddr"}, mem_addr, addr[9:2]);
        check({name, "_stall0"}, stall, 1);
        for (int i = 0; i < waits; i++) begin
            tick();
            idle_in();
            #4;
            check({name, "_wait_stall"}, stall, 1);
            check({name, "_wait_noreq"}, mem_request, 0);
        end
        tick();
        idle_in();
        mem_valid = 1'b1;
        mem_rdata = word;
        #4;
        check({name, "_vld_stall"}, stall, 1);
        check({name, "_vld_noreq"}, mem_request, 0);
        tick();
        mem_valid = 1'b0;
        mem_rdata = '0;
        exp_wb    = exp;
        check({name, "_wb_valid"}, wb_valid, 1);
        check({name, "_wb_data"},  wb_data, exp);
        check({name, "_wb_stall"}, stall, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         ld    st    f3      addr           rs2            we    req   mask     maddr  wdata          e     code
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678, 1'b1, 1'b1, 4'b0010, 8'h00, 32'h7878_7878, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 1'b1, 1'b1, 4'b1000, 8'h00, 32'hA5A5_A5A5, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h0000_ABCD, 1'b1, 1'b1, 4'b1100, 8'h01, 32'hABCD_ABCD, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0004, 32'h1111_2222, 1'b1, 1'b1, 4'b0011, 8'h01, 32'h2222_2222, 1'b0, 2'b00};
        vecs[4]  = '{1'b0, 1'b1, 3'b010, 32'h0000_03FC, 32'hCAFE_F00D, 1'b1, 1'b1, 4'b1111, 8'hFF, 32'hCAFE_F00D, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'hFFFF_F008, 32'h0102_0304, 1'b1, 1'b1, 4'b1111, 8'h02, 32'h0102_0304, 1'b0, 2'b00};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0005, 32'h0000_1111, 1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b01};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0002, 32'h0000_2222, 1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b01};
        vecs[8]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0000_3333, 1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b10};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0001, 32'h0,          1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b10};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0,          1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b01};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0,          1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b01};
        vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h0000_0010, 32'h0000_4444, 1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b0, 2'b00};
        vecs[13] = '{1'b0, 1'b1, 3'b111, 32'h0000_0001, 32'h0000_5555, 1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b10};
        vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h0000_0001, 32'h0,          1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b01};
        vecs[15] = '{1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0,          1'b0, 1'b0, 4'b0000, 8'h00, 32'h0,          1'b1, 2'b10};

        // Reset state
        #12;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data",  wb_data, 0);
        check("rst_err",      err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_stall",    stall, 0);
        check("rst_mem_req",  mem_request, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Loads: basic word, back-to-back byte pair, halves with wait cycles
        do_load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("wb_pulse_one_cycle", wb_valid, 0);
        check("wb_data_held", wb_data, 32'hDEAD_BEEF);
        do_load("lb13",  3'b000, 32'h13, 32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0);
        do_load("lbu13", 3'b100, 32'h13, 32'h80FF_1234, 0, 32'h0000_0080, 1'b0);
        do_load("lh02",  3'b001, 32'h02, 32'h80FF_1234, 2, 32'hFFFF_80FF, 1'b0);
        do_load("lh00",  3'b001, 32'h00, 32'h1234_ABCD, 1, 32'hFFFF_ABCD, 1'b0);
        do_load("lhu0e", 3'b101, 32'h0E, 32'h9876_5432, 0, 32'h0000_9876, 1'b0);
        do_load("lb21",  3'b000, 32'h21, 32'h0000_7F00, 3, 32'h0000_007F, 1'b0);
        do_load("lbu20", 3'b100, 32'h20, 32'h0000_00F0, 0, 32'h0000_00F0, 1'b0);

        // Single-cycle store / reject vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].rs2);
            #4;
            check($sformatf("v%0d_we", i),    mem_we_re,   vecs[i].we);
            check($sformatf("v%0d_req", i),   mem_request, vecs[i].req);
            check($sformatf("v%0d_load", i),  mem_load,    0);
            check($sformatf("v%0d_mask", i),  mem_mask,    vecs[i].mask);
            check($sformatf("v%0d_maddr", i), mem_addr,    vecs[i].maddr);
            check($sformatf("v%0d_wdata", i), mem_wdata,   vecs[i].wdata);
            check($sformatf("v%0d_stall", i), stall,       0);
            tick();
            if (vecs[i].e) exp_code = vecs[i].code;
            check($sformatf("v%0d_err", i),      err,      vecs[i].e);
            check($sformatf("v%0d_err_code", i), err_code, exp_code);
            check($sformatf("v%0d_wb_valid", i), wb_valid, 0);
            check($sformatf("v%0d_wb_data", i),  wb_data,  exp_wb);
        end

        // Timeout: 8 WAIT cycles without mem_valid
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        #4;
        check("to_req", mem_request, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            idle_in();
            #4;
            check($sformatf("to_w%0d_stall", i), stall, 1);
            check($sformatf("to_w%0d_err", i),   err, 0);
        end
        tick();
        check("to_err",      err, 1);
        check("to_err_code", err_code, 2'b11);
        check("to_wb_valid", wb_valid, 0);
        check("to_stall",    stall, 0);
        drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h0000_0005);
        #4;
        check("to_idle_store_req", mem_request, 1);
        check("to_idle_store_we",  mem_we_re, 1);
        tick();
        idle_in();
        check("to_err_pulse",  err, 0);
        check("to_code_held",  err_code, 2'b11);
        mem_valid = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_valid = 1'b0;
        check("idle_mem_valid_ignored", wb_valid, 0);
        check("idle_wb_data_kept", wb_data, exp_wb);

        // load_en and store_en together: load wins
        do_load("both", 3'b010, 32'h08, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b1);

        // Reset during WAIT
        drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        #4;
        check("rw_req", mem_request, 1);
        tick();
        idle_in();
        #2;
        rst = 1'b0;
        #1;
        check("rw_wb_valid", wb_valid, 0);
        check("rw_wb_data",  wb_data, 0);
        check("rw_err",      err, 0);
        check("rw_err_code", err_code, 0);
        check("rw_stall",    stall, 0);
        check("rw_mem_req",  mem_request, 0);
        @(negedge clk);
        rst = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        check("rw_post1_wb_valid", wb_valid, 0);
        tick();
        mem_valid = 1'b0;
        check("rw_post2_wb_valid", wb_valid, 0);
        check("rw_post_wb_data",   wb_data, 0);
        check("rw_post_stall",     stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
